dmem_responder: RTL and testbench

Data-memory responder on the far side of the memory-stage address/write-enable interface. It takes a load or store request from the pipeline's memory stage and holds the pipeline with `stall` for a fixed, parameterised access latency. It then commits the store, or returns load data with a one-cycle valid pulse. Storage is a word-addressed array of 2**ADDR_W words.

---
 rtl/dmem_responder_pkg.sv | 13 +
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder_array.sv | 33 +++
 rtl/dmem_responder.sv | 91 +++++++++
 tb/tb_dmem_responder.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared types and default widths for the data-memory responder.
//   DEF_ADDR_W / DEF_DATA_W : default word-address and data widths
//   state_t                 : responder FSM states
//   req_kind_t              : kind of the accepted request
package mem_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {LOAD, STORE} req_kind_t;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: memory-stage request/response bundle.
//   req_addr, req_re, req_we, req_wdata : request from the pipeline (master -> slave)
//   stall                               : combinational pipeline hold (slave -> master)
//   rdata, rvalid                       : registered load data and its one-cycle valid pulse
//   wack                                : one-cycle store-committed pulse
interface dmem_responder_if import mem_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [ADDR_W-1:0] req_addr;
    logic              req_re;
    logic              req_we;
    logic [DATA_W-1:0] req_wdata;
    logic              stall;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              wack;

    modport master (output req_addr, req_re, req_we, req_wdata, input stall, rdata, rvalid, wack);
    modport slave  (input req_addr, req_re, req_we, req_wdata, output stall, rdata, rvalid, wack);

endinterface

// File: rtl/dmem_responder_array.sv
// dmem_array: word-addressed storage with a synchronous write port and a registered read.
//   clock, reset : clock; async active-low reset (clears only the read register)
//   we, addr, wdata : write mem[addr] = wdata on the rising edge when we=1
//   re, rdata       : on re=1 capture mem[addr] into rdata, which otherwise holds
module dmem_array #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_d, rdata_q;

    always_comb rdata_d = re ? mem[addr] : rdata_q;

    // Storage itself is deliberately not reset.
    always_ff @(posedge clock)
        if (we) mem[addr] <= wdata;

    always_ff @(posedge clock or negedge reset)
        if (!reset) rdata_q <= '0;
        else        rdata_q <= rdata_d;

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: holds the pipeline for LATENCY busy cycles, then commits a store or returns load data.
//   clock, reset : clock; async active-low reset (aborts any uncommitted access)
//   bus (slave)  : request in; stall (combinational), rdata, rvalid, wack (registered) out
module dmem_responder import mem_pkg::*; #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LATENCY = 2
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int CNT_W = 4;

    state_t            state_d, state_q;
    req_kind_t         kind_d, kind_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] wdata_d, wdata_q;
    logic              rvalid_d, rvalid_q;
    logic              wack_d, wack_q;
    logic              commit;
    logic              req;

    assign req = bus.req_re | bus.req_we;

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rvalid_d = 1'b0;
        wack_d   = 1'b0;
        commit   = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                addr_d  = bus.req_addr;
                wdata_d = bus.req_wdata;
                // A simultaneous read and write is served as a load only.
                kind_d  = bus.req_re ? LOAD : STORE;
                cnt_d   = CNT_W'(LATENCY - 1);
                state_d = BUSY;
            end
            BUSY: if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                commit   = 1'b1;
                rvalid_d = kind_q == LOAD;
                wack_d   = kind_q == STORE;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state_q  <= IDLE;
            kind_q   <= LOAD;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            wack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            wack_q   <= wack_d;
        end

    dmem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
        .clock (clock),
        .reset (reset),
        .we    (commit && kind_q == STORE),
        .re    (commit && kind_q == LOAD),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (bus.rdata)
    );

    assign bus.stall  = (state_q == IDLE && req) || state_q == BUSY;
    assign bus.rvalid = rvalid_q;
    assign bus.wack   = wack_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder at LATENCY 2, 1 and 15.
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [6:0]  addr = '0;
    logic [31:0] wdata = '0;
    int          sel = 0;
    int          errors = 0;
    int          checks = 0;

    logic        m_stall, m_rvalid, m_wack;
    logic [31:0] m_rdata;

    always #5 clock = ~clock;

    dmem_responder_if #(.ADDR_W(7), .DATA_W(32)) b2 ();
    dmem_responder_if #(.ADDR_W(7), .DATA_W(32)) b1 ();
    dmem_responder_if #(.ADDR_W(7), .DATA_W(32)) b15 ();

    assign b2.req_re     = re & (sel == 0);
    assign b2.req_we     = we & (sel == 0);
    assign b2.req_addr   = addr;
    assign b2.req_wdata  = wdata;
    assign b1.req_re     = re & (sel == 1);
    assign b1.req_we     = we & (sel == 1);
    assign b1.req_addr   = addr;
    assign b1.req_wdata  = wdata;
    assign b15.req_re    = re & (sel == 2);
    assign b15.req_we    = we & (sel == 2);
    assign b15.req_addr  = addr;
    assign b15.req_wdata = wdata;

    dmem_responder #(.ADDR_W(7), .DATA_W(32), .LATENCY(2))  u_lat2  (.clock(clock), .reset(reset), .bus(b2));
    dmem_responder #(.ADDR_W(7), .DATA_W(32), .LATENCY(1))  u_lat1  (.clock(clock), .reset(reset), .bus(b1));
    dmem_responder #(.ADDR_W(7), .DATA_W(32), .LATENCY(15)) u_lat15 (.clock(clock), .reset(reset), .bus(b15));

    always_comb begin
        m_stall  = sel == 0 ? b2.stall  : sel == 1 ? b1.stall  : b15.stall;
        m_rvalid = sel == 0 ? b2.rvalid : sel == 1 ? b1.rvalid : b15.rvalid;
        m_wack   = sel == 0 ? b2.wack   : sel == 1 ? b1.wack   : b15.wack;
        m_rdata  = sel == 0 ? b2.rdata  : sel == 1 ? b1.rdata  : b15.rdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts just after a rising edge and ends just after a rising edge.
    task automatic access(input string tag, input logic r, input logic w, input logic [6:0] a,
                          input logic [31:0] d, input int exp_w, input logic [31:0] exp_rd);
        int n = 0;
        int early = 0;
        re = r; we = w; addr = a; wdata = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!m_stall) break;
            n++;
            early += int'(m_rvalid | m_wack);
        end
        check({tag, " stall_width"}, 32'(n), 32'(exp_w));
        check({tag, " early_pulse"}, 32'(early), 32'd0);
        check({tag, " rvalid"}, 32'(m_rvalid), 32'(r));
        check({tag, " wack"}, 32'(m_wack), 32'(w & ~r));
        if (r) check({tag, " rdata"}, m_rdata, exp_rd);
        @(posedge clock); #1;
        re = 1'b0; we = 1'b0;
        @(negedge clock);
        check({tag, " pulse_end"}, 32'(m_rvalid | m_wack), 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clock);
        #1;
        check("rst stall", 32'(m_stall), 32'd0);
        check("rst rvalid", 32'(m_rvalid), 32'd0);
        check("rst wack", 32'(m_wack), 32'd0);
        check("rst rdata", m_rdata, 32'd0);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;

        n = 0;
        repeat (5) begin
            @(negedge clock);
            n += int'(m_stall);
        end
        check("idle stall", 32'(n), 32'd0);
        @(posedge clock); #1;

        access("st05", 1'b0, 1'b1, 7'h05, 32'hDEADBEEF, 3, 32'h0);
        access("ld05", 1'b1, 1'b0, 7'h05, 32'h0, 3, 32'hDEADBEEF);

        access("st10", 1'b0, 1'b1, 7'h10, 32'h0, 3, 32'h0);
        access("rw10", 1'b1, 1'b1, 7'h10, 32'h12345678, 3, 32'h0);
        access("ld10", 1'b1, 1'b0, 7'h10, 32'h0, 3, 32'h0);

        access("st02", 1'b0, 1'b1, 7'h02, 32'h13572468, 3, 32'h0);
        re = 1'b0; we = 1'b1; addr = 7'h01; wdata = 32'hAAAA0000;
        @(posedge clock); #1;
        addr = 7'h02; wdata = 32'h55555555;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!m_stall) break;
            n++;
        end
        check("chg stall_width", 32'(n), 32'd3);
        check("chg wack", 32'(m_wack), 32'd1);
        @(posedge clock); #1;
        we = 1'b0;
        @(posedge clock); #1;
        access("chg ld01", 1'b1, 1'b0, 7'h01, 32'h0, 3, 32'hAAAA0000);
        access("chg ld02", 1'b1, 1'b0, 7'h02, 32'h0, 3, 32'h13572468);

        access("st7f", 1'b0, 1'b1, 7'h7F, 32'hCAFEF00D, 3, 32'h0);
        access("st00", 1'b0, 1'b1, 7'h00, 32'h0BADF00D, 3, 32'h0);
        access("ld7f", 1'b1, 1'b0, 7'h7F, 32'h0, 3, 32'hCAFEF00D);
        access("ld00", 1'b1, 1'b0, 7'h00, 32'h0, 3, 32'h0BADF00D);

        re = 1'b0; we = 1'b1; addr = 7'h7F; wdata = 32'hFFFFFFFF;
        @(posedge clock); #1;
        we = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rst stall", 32'(m_stall), 32'd0);
        check("mid_rst rdata", m_rdata, 32'd0);
        check("mid_rst rvalid", 32'(m_rvalid), 32'd0);
        check("mid_rst wack", 32'(m_wack), 32'd0);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
        access("post_rst ld7f", 1'b1, 1'b0, 7'h7F, 32'h0, 3, 32'hCAFEF00D);

        sel = 1;
        access("l1 st33", 1'b0, 1'b1, 7'h33, 32'h11112222, 2, 32'h0);
        access("l1 ld33", 1'b1, 1'b0, 7'h33, 32'h0, 2, 32'h11112222);
        sel = 2;
        access("l15 st33", 1'b0, 1'b1, 7'h33, 32'h33334444, 16, 32'h0);
        access("l15 ld33", 1'b1, 1'b0, 7'h33, 32'h0, 16, 32'h33334444);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
